// File: rtl/menu_cursor_ctrl.sv
// menu_cursor_ctrl: selected-row register and blinking cursor box for the title menu.
// Up/down presses step the selected row. A select press flashes the cursor, then
// pulses mode_valid with the chosen row. display is ORed with the menu text pixel.
//
// Optional build macro: MENU_WRAP_EN. When defined, up/down wrap around the row range;
// otherwise they saturate at the end rows.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   frame_tick            one-cycle pulse per video frame
//   menu_en               high while the game FSM shows the menu
//   btn_up/down/sel       raw button levels (asynchronous to clk)
//   start_x, start_y      menu origin
//   x, y                  current pixel position
//   display               registered cursor pixel
//   sel_index             currently selected row
//   mode_valid            one-cycle pulse when the selection is committed
//   busy                  high while the confirm flash runs
module menu_cursor_ctrl #(
    parameter int unsigned N_OPTIONS    = 2,
    parameter int unsigned ROW_Y0       = 130,
    parameter int unsigned ROW_PITCH    = 80,
    parameter int unsigned CURSOR_X     = 10,
    parameter int unsigned CURSOR_W     = 20,
    parameter int unsigned CURSOR_H     = 20,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned FLASH_FRAMES = 60,
    localparam int unsigned IDX_W       = (N_OPTIONS > 2) ? $clog2(N_OPTIONS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             menu_en,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_sel,
    input  logic [9:0]       start_x,
    input  logic [9:0]       start_y,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    output logic             display,
    output logic [IDX_W-1:0] sel_index,
    output logic             mode_valid,
    output logic             busy
);

    localparam int unsigned CNT_MAX = (BLINK_FRAMES > FLASH_FRAMES) ? BLINK_FRAMES : FLASH_FRAMES;
    localparam int unsigned CNT_W   = (CNT_MAX < 4) ? 2 : $clog2(CNT_MAX + 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_OPTIONS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BROWSE,
        ST_FLASH,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;
    logic             disp_q, disp_d;
    logic             mv_q, mv_d;
    logic             busy_q, busy_d;

    // Synchroniser stages (s1, s2) and previous-level flop per button
    logic [2:0] up_sync_q, down_sync_q, sel_sync_q;
    logic       up_p, down_p, sel_p;

    logic [IDX_W-1:0] tgt_idx;
    logic [CNT_W-1:0] cnt_inc;
    logic [10:0]      box_x0, box_x1, row_top, row_bot, px, py;
    logic             hit;

    // Rising-edge press pulses from the synchronised levels
    assign up_p   = up_sync_q[1]   & ~up_sync_q[2];
    assign down_p = down_sync_q[1] & ~down_sync_q[2];
    assign sel_p  = sel_sync_q[1]  & ~sel_sync_q[2];

    // Candidate index for a single up or down press; equals sel_q when no move applies
    always_comb begin
        tgt_idx = sel_q;
        if (up_p && !down_p) begin
            if (sel_q != '0) begin
                tgt_idx = sel_q - IDX_W'(1);
            end
`ifdef MENU_WRAP_EN
            else begin
                tgt_idx = IDX_MAX;
            end
`endif
        end else if (down_p && !up_p) begin
            if (sel_q != IDX_MAX) begin
                tgt_idx = sel_q + IDX_W'(1);
            end
`ifdef MENU_WRAP_EN
            else begin
                tgt_idx = '0;
            end
`endif
        end
    end

    // Cursor box geometry, 11-bit so the sums never wrap
    always_comb begin
        px      = 11'(x);
        py      = 11'(y);
        box_x0  = 11'(start_x) + 11'(CURSOR_X);
        box_x1  = box_x0 + 11'(CURSOR_W);
        row_top = 11'(start_y) + 11'(ROW_Y0) + 11'(sel_q) * 11'(ROW_PITCH);
        row_bot = row_top + 11'(CURSOR_H);
        hit     = (px >= box_x0) && (px < box_x1) && (py >= row_top) && (py < row_bot);
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        blink_d = blink_q;
        mv_d    = 1'b0;
        cnt_inc = cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (menu_en) begin
                    state_d = ST_BROWSE;
                    cnt_d   = '0;
                    blink_d = 1'b1;
                end
            end
            ST_BROWSE: begin
                if (!menu_en) begin
                    state_d = ST_IDLE;
                end else if (sel_p) begin
                    state_d = ST_FLASH;
                    cnt_d   = '0;
                    blink_d = 1'b1;
                end else if (tgt_idx != sel_q) begin
                    // A move restarts the blink so the cursor shows at once
                    sel_d   = tgt_idx;
                    cnt_d   = '0;
                    blink_d = 1'b1;
                end else if (frame_tick) begin
                    if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                        cnt_d   = '0;
                        blink_d = ~blink_q;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_FLASH: begin
                if (!menu_en) begin
                    state_d = ST_IDLE;
                end else if (frame_tick) begin
                    if (cnt_inc == CNT_W'(FLASH_FRAMES)) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                        blink_d = 1'b1;
                        mv_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                        // Fast flash: toggle every fourth frame
                        if (cnt_inc[1:0] == 2'b00) begin
                            blink_d = ~blink_q;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (!menu_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_FLASH);
        disp_d = hit && blink_q && (state_q != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            blink_q     <= 1'b1;
            disp_q      <= 1'b0;
            mv_q        <= 1'b0;
            busy_q      <= 1'b0;
            up_sync_q   <= '0;
            down_sync_q <= '0;
            sel_sync_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            blink_q     <= blink_d;
            disp_q      <= disp_d;
            mv_q        <= mv_d;
            busy_q      <= busy_d;
            up_sync_q   <= {up_sync_q[1:0], btn_up};
            down_sync_q <= {down_sync_q[1:0], btn_down};
            sel_sync_q  <= {sel_sync_q[1:0], btn_sel};
        end
    end

    assign display    = disp_q;
    assign sel_index  = sel_q;
    assign mode_valid = mv_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_menu_cursor_ctrl.sv
// Randomised scoreboard bench for menu_cursor_ctrl with a behavioural menu model.
module tb_menu_cursor_ctrl;

    localparam int N_OPT   = 2;
    localparam int IDX_W   = (N_OPT > 2) ? $clog2(N_OPT) : 1;
    localparam int ROW_Y0  = 130;
    localparam int PITCH   = 80;
    localparam int CUR_X   = 10;
    localparam int CUR_W   = 20;
    localparam int CUR_H   = 20;
    localparam int BLINK_F = 30;
    localparam int FLASH_F = 60;

    localparam int M_IDLE   = 0;
    localparam int M_BROWSE = 1;
    localparam int M_FLASH  = 2;
    localparam int M_DONE   = 3;

    logic             clk = 1'b1;
    logic             reset = 1'b1;
    logic             frame_tick = 1'b0;
    logic             menu_en = 1'b0;
    logic             btn_up = 1'b0;
    logic             btn_down = 1'b0;
    logic             btn_sel = 1'b0;
    logic [9:0]       start_x = '0;
    logic [9:0]       start_y = '0;
    logic [9:0]       x = '0;
    logic [9:0]       y = '0;
    logic             display;
    logic [IDX_W-1:0] sel_index;
    logic             mode_valid;
    logic             busy;

    menu_cursor_ctrl #(
        .N_OPTIONS(N_OPT), .ROW_Y0(ROW_Y0), .ROW_PITCH(PITCH), .CURSOR_X(CUR_X),
        .CURSOR_W(CUR_W), .CURSOR_H(CUR_H), .BLINK_FRAMES(BLINK_F), .FLASH_FRAMES(FLASH_F)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .menu_en(menu_en),
        .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
        .start_x(start_x), .start_y(start_y), .x(x), .y(y),
        .display(display), .sel_index(sel_index), .mode_valid(mode_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int disp;
        int sel;
        int mv;
        int busy;
    } exp_t;

    exp_t exp_q[$];
    int   commit_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   commits_expected = 0;
    int   commits_seen = 0;

    // Behavioural model state: mode, chosen row, frames since the blink phase restarted
    int       m_mode = M_IDLE;
    int       m_sel = 0;
    int       m_ticks = 0;
    bit [2:0] hu = '0, hd = '0, hs = '0;   // [0] newest sampled level

    function automatic bit in_box(int px, int py, int idx);
        int bx  = int'(start_x) + CUR_X;
        int top = int'(start_y) + ROW_Y0 + idx * PITCH;
        return (px >= bx) && (px < bx + CUR_W) && (py >= top) && (py < top + CUR_H);
    endfunction

    // Predict DUT outputs after the coming clock edge from the current inputs
    task automatic model_edge();
        exp_t e;
        bit   pu, pd, ps, blink;
        int   tgt;
        if (reset) begin
            m_mode = M_IDLE; m_sel = 0; m_ticks = 0;
            hu = '0; hd = '0; hs = '0;
            e = '{0, 0, 0, 0};
            exp_q.push_back(e);
            return;
        end
        // A level is seen as a press two edges after it is first sampled
        pu = hu[1] & ~hu[2];
        pd = hd[1] & ~hd[2];
        ps = hs[1] & ~hs[2];
        hu = {hu[1:0], btn_up};
        hd = {hd[1:0], btn_down};
        hs = {hs[1:0], btn_sel};

        case (m_mode)
            M_BROWSE: blink = ((m_ticks / BLINK_F) % 2) == 0;
            M_FLASH:  blink = ((m_ticks / 4) % 2) == 0;
            M_DONE:   blink = 1'b1;
            default:  blink = 1'b0;
        endcase
        e.disp = (blink && m_mode != M_IDLE && in_box(int'(x), int'(y), m_sel)) ? 1 : 0;
        e.mv   = 0;

        tgt = m_sel;
        if (pu && !pd) begin
`ifdef MENU_WRAP_EN
            tgt = (m_sel == 0) ? N_OPT - 1 : m_sel - 1;
`else
            tgt = (m_sel == 0) ? 0 : m_sel - 1;
`endif
        end else if (pd && !pu) begin
`ifdef MENU_WRAP_EN
            tgt = (m_sel == N_OPT - 1) ? 0 : m_sel + 1;
`else
            tgt = (m_sel == N_OPT - 1) ? m_sel : m_sel + 1;
`endif
        end

        case (m_mode)
            M_IDLE: if (menu_en) begin m_mode = M_BROWSE; m_ticks = 0; end
            M_BROWSE: begin
                if (!menu_en) m_mode = M_IDLE;
                else if (ps) begin m_mode = M_FLASH; m_ticks = 0; end
                else if (tgt != m_sel) begin m_sel = tgt; m_ticks = 0; end
                else if (frame_tick) m_ticks++;
            end
            M_FLASH: begin
                if (!menu_en) m_mode = M_IDLE;
                else if (frame_tick) begin
                    m_ticks++;
                    if (m_ticks == FLASH_F) begin
                        m_mode = M_DONE;
                        e.mv = 1;
                        commit_q.push_back(m_sel);
                        commits_expected++;
                    end
                end
            end
            default: if (!menu_en) m_mode = M_IDLE;
        endcase
        e.sel  = m_sel;
        e.busy = (m_mode == M_FLASH) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    task automatic check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: compare each cycle's outputs, and each commit pulse against the commit queue
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("display", int'(display), e.disp);
                check("sel_index", int'(sel_index), e.sel);
                check("busy", int'(busy), e.busy);
                check("mode_valid", int'(mode_valid), e.mv);
                if (mode_valid) begin
                    commits_seen++;
                    if (commit_q.size() == 0) check("commit_unexpected", 1, 0);
                    else check("commit_index", int'(sel_index), commit_q.pop_front());
                end
            end
        end
    end

    // Drive current inputs through one clock edge
    task automatic cyc(int n);
        repeat (n) begin
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic ticks(int n_cycles);
        for (int i = 0; i < n_cycles; i++) begin
            frame_tick = (i % 2 == 0);
            cyc(1);
        end
        frame_tick = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        cyc(3);
        reset = 1'b0;
        // Row 0 at (115,185), row 1 at (115,265)
        start_x = 10'd100; start_y = 10'd50; x = 10'd115; y = 10'd185;
        menu_en = 1'b1;
        cyc(4);
        y = 10'd265; cyc(3);
        btn_down = 1'b1;
        for (int i = 0; i < 500; i++) begin
            y = (i % 2 == 0) ? 10'd265 : 10'd185;
            cyc(1);
        end
        btn_down = 1'b0; cyc(4);
        btn_up = 1'b1; btn_down = 1'b1; cyc(6);
        btn_up = 1'b0; btn_down = 1'b0; cyc(4);
        y = 10'd265;
        ticks(130);
        btn_sel = 1'b1; cyc(3); btn_sel = 1'b0;
        ticks(130);
        btn_up = 1'b1; cyc(8); btn_up = 1'b0; cyc(4);
        menu_en = 1'b0; cyc(3); menu_en = 1'b1; cyc(3);
        // Reset in the middle of the flash
        btn_sel = 1'b1; cyc(4); btn_sel = 1'b0;
        ticks(20);
        reset = 1'b1; cyc(2); reset = 1'b0; cyc(3);
        // Up at row 0
        y = 10'd185;
        btn_up = 1'b1; cyc(6); btn_up = 1'b0; cyc(4);
        btn_up = 1'b1; cyc(6); btn_up = 1'b0; cyc(4);

        // Randomised phase, pixels biased around the cursor column and rows
        for (int i = 0; i < 12000; i++) begin
            if (i % 700 == 0) begin
                start_x = 10'($urandom_range(0, 600));
                start_y = 10'($urandom_range(0, 500));
            end
            frame_tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 11) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, 11) == 0) btn_down = ~btn_down;
            if ($urandom_range(0, 29) == 0) btn_sel = ~btn_sel;
            if ($urandom_range(0, 399) == 0) menu_en = ~menu_en;
            reset = ($urandom_range(0, 2999) == 0);
            x = 10'(int'(start_x) + CUR_X - 3 + int'($urandom_range(0, CUR_W + 5)));
            y = 10'(int'(start_y) + ROW_Y0 - 3 + int'($urandom_range(0, N_OPT * PITCH)));
            cyc(1);
        end
        reset = 1'b0; frame_tick = 1'b0;
        cyc(4);
        @(posedge clk); #2;
        check("commit_count", commits_seen, commits_expected);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/menu_cursor_ctrl.md
Name: menu_cursor_ctrl

Overview:
- Sequential successor to the static title/menu text renderer.
- Holds the selected menu row (parametrised option count) and steps it with up/down buttons.
- Draws a blinking cursor box beside the selected row; flashes it on confirm, then pulses the chosen mode index to the game FSM.
- Sits between the button synchronisers and the VGA pixel OR-tree. Its cursor pixel is ORed with the menu text pixel.

Parameters:
- N_OPTIONS, 2, number of selectable rows (2..8); IDX_W = $clog2(N_OPTIONS), min 1.
- ROW_Y0, 130, y offset of row 0 top from start_y.
- ROW_PITCH, 80, vertical distance between rows.
- CURSOR_X, 10, x offset of cursor box from start_x.
- CURSOR_W, 20, cursor box width in pixels.
- CURSOR_H, 20, cursor box height in pixels.
- BLINK_FRAMES, 30, frame ticks per blink half-period in BROWSE.
- FLASH_FRAMES, 60, total frame ticks spent in FLASH.

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- menu_en  in  1  level; high while the game FSM shows the menu
- btn_up  in  1  raw button level, asynchronous to clk
- btn_down  in  1  raw button level
- btn_sel  in  1  raw button level
- start_x  in  10  menu origin x
- start_y  in  10  menu origin y
- x  in  10  current pixel x
- y  in  10  current pixel y
- display  out  1  cursor pixel, registered
- sel_index  out  IDX_W  currently selected row
- mode_valid  out  1  one-cycle pulse when the selection is committed
- busy  out  1  high in FLASH

Behaviour:
- Reset (async, any state): state=IDLE, sel_index=0, display=0, mode_valid=0, busy=0, blink_on=1, blink counter=0, synchroniser/edge flops=0.
- Buttons: 2-flop synchroniser each, then rising-edge detect → 1-cycle press pulses up_p/down_p/sel_p. Held buttons give one pulse only.
- States:
  - IDLE: cursor hidden, presses ignored. menu_en=1 → BROWSE, blink_on=1, counter=0. sel_index is retained from the previous pick.
  - BROWSE: handle presses. On each frame_tick the counter increments; at BLINK_FRAMES-1 it clears and blink_on toggles. menu_en=0 → IDLE.
  - FLASH: presses ignored. blink_on toggles every 4 frame ticks. After FLASH_FRAMES ticks → DONE, mode_valid=1 for exactly that one cycle. menu_en=0 → IDLE, no pulse.
  - DONE: cursor shown steady, presses ignored. menu_en=0 → IDLE.
- Press priority in BROWSE, same cycle: sel_p wins → FLASH, counter=0, blink_on=1, busy=1. Otherwise up_p and down_p together → no move. up_p alone → index-1. down_p alone → index+1. Boundary handling is under Optional Feature.
- Any index change in BROWSE resets the counter to 0 and sets blink_on=1, so the cursor is visible immediately after a move.
- Geometry (11-bit arithmetic, no wrap):
  - row_top = start_y + ROW_Y0 + sel_index*ROW_PITCH
  - hit when start_x+CURSOR_X ≤ x < start_x+CURSOR_X+CURSOR_W and row_top ≤ y < row_top+CURSOR_H.
- display is registered. It equals hit & blink_on & (state≠IDLE), 1 clk after x/y are presented.
- sel_index is stable in FLASH/DONE and equals the committed index when mode_valid fires.

Optional Feature:
- Macro MENU_WRAP_EN.
- Defined: up at 0 → N_OPTIONS-1; down at N_OPTIONS-1 → 0.
- Undefined: the index saturates at 0 / N_OPTIONS-1. A press at the limit does not reset blink.

Test Plan:
- Reset mid-FLASH → next cycle state IDLE, sel_index=0, display=0, busy=0, no mode_valid.
- menu_en=1, N_OPTIONS=2, start=(100,50), pixel (115,185) → display=1 one clk later; pixel (115,265) → 0. Press down → pixel (115,265)=1, pixel (115,185)=0.
- Hold btn_down 500 cycles → index moves by exactly 1. btn_up and btn_down rising in the same cycle → index unchanged.
- BROWSE with no press, 30 frame ticks → display toggles to 0 at the 30th tick and back to 1 at the 60th.
- btn_sel at index 1 → busy=1. After 60 frame ticks, mode_valid=1 for one cycle with sel_index=1; further btn_up has no effect.
- Index 0 + btn_up: without MENU_WRAP_EN → stays 0; with it → 1 (N_OPTIONS=2), 2 (N_OPTIONS=3).
